// File: rtl/operand_entry_ctrl.sv
// Button-driven sequencer for the hex adder's 2-slot operand memory (A then B, then show sum).
// Define DEBOUNCE_EN to include the per-button debounce filter; without it the synchronized level is used directly.
module operand_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int CLEAR_CYCLES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enterBtn,
   input  logic       clearBtn,
   output logic       selector,
   output logic       activate,
   output logic       memReset,
   output logic       sumValid,
   output logic [2:0] stage
);

   localparam logic [2:0] WAIT_A  = 3'd0;
   localparam logic [2:0] WRITE_A = 3'd1;
   localparam logic [2:0] WAIT_B  = 3'd2;
   localparam logic [2:0] WRITE_B = 3'd3;
   localparam logic [2:0] SHOW    = 3'd4;
   localparam logic [2:0] CLEAR   = 3'd5;

   localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);

   // Bit 0 carries the enter button, bit 1 the clear button.
   logic [1:0] btn;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] lvl;
   logic [1:0] lvl_d;
   logic [1:0] pulse;
   logic       enter_p;
   logic       clear_p;

   assign btn = {clearBtn, enterBtn};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] db_cnt [2];
   logic [1:0]       filt;

   // Any cycle where the synchronized level agrees with the filtered one restarts the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         filt      <= '1;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign lvl = filt;
`else
   // Debounce sizing only matters to the filtered build; the mask below is constant all-ones.
   localparam bit DB_CFG_OK = (DEBOUNCE_CYCLES > 0) && (CNT_W > 0);
   assign lvl = sync2 & {2{DB_CFG_OK | 1'b1}};
`endif

   // Registered falling-edge detect: one pulse per accepted press, none while held.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lvl_d <= '1;
         pulse <= '0;
      end else begin
         lvl_d <= lvl;
         pulse <= lvl_d & ~lvl;
      end
   end

   assign enter_p = pulse[0];
   assign clear_p = pulse[1];

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic [CW-1:0] clr_cnt;
   logic [CW-1:0] clr_cnt_nx;

   // Clear wins over a same-cycle enter; enter seen during a WRITE state is dropped.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = '0;
      if (clear_p) begin
         state_nx = CLEAR;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_cnt == CLEAR_LAST) state_nx = WAIT_A;
               else clr_cnt_nx = clr_cnt + CW'(1);
            end
            WAIT_A:  if (enter_p) state_nx = WRITE_A;
            WRITE_A: state_nx = WAIT_B;
            WAIT_B:  if (enter_p) state_nx = WRITE_B;
            WRITE_B: state_nx = SHOW;
            SHOW:    if (enter_p) state_nx = WAIT_A;
            default: state_nx = CLEAR;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         selector <= 1'b0;
         activate <= 1'b1;
         memReset <= 1'b0;
         sumValid <= 1'b0;
      end else begin
         state    <= state_nx;
         clr_cnt  <= clr_cnt_nx;
         selector <= (state_nx == WAIT_B) || (state_nx == WRITE_B) || (state_nx == SHOW);
         activate <= !((state_nx == WRITE_A) || (state_nx == WRITE_B));
         memReset <= (state_nx != CLEAR);
         sumValid <= (state_nx == SHOW);
      end
   end

   assign stage = state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: window-based button acceptance model plus a phase-table FSM model.
// Follows DEBOUNCE_EN the same way the design does.
module tb_operand_entry_ctrl;

   localparam int D   = 4;
   localparam int CLR = 2;
   localparam int HW  = D + 1;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enterBtn = 1'b1;
   logic       clearBtn = 1'b1;
   logic       selector;
   logic       activate;
   logic       memReset;
   logic       sumValid;
   logic [2:0] stage;

   int checks = 0;
   int passed = 0;
   int mism = 0;
   int prop_bad = 0;
   int dut_writes = 0;
   int m_writes = 0;
   logic [6:0] last_got;
   logic [6:0] last_exp;
   logic prev_act = 1'b1;

   operand_entry_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .CLEAR_CYCLES(CLR)) dut (
      .clock(clock), .reset(reset), .enterBtn(enterBtn), .clearBtn(clearBtn),
      .selector(selector), .activate(activate), .memReset(memReset),
      .sumValid(sumValid), .stage(stage)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   logic [HW:0] e_hist, c_hist;
   logic        e_lvl, c_lvl, nl;
   logic [1:0]  e_dly, c_dly;
   int          m_phase, m_left;

   // A level is accepted once the last D synchronized samples all disagree with it.
   function automatic logic next_level(input logic [HW:0] h, input logic lvl);
`ifdef DEBOUNCE_EN
      for (int i = 2; i <= D + 1; i++) if (h[i] == lvl) return lvl;
      return !lvl;
`else
      return h[1];
`endif
   endfunction

   function automatic logic [6:0] exp_vec(input int p);
      logic sel;
      sel = (p == 2) || (p == 3) || (p == 4);
      return {3'(p), sel, !((p == 1) || (p == 3)), (p != 5), (p == 4)};
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         e_hist = '1; c_hist = '1; e_lvl = 1'b1; c_lvl = 1'b1;
         e_dly = '0; c_dly = '0; m_phase = 5; m_left = CLR;
      end else begin
         if (c_dly[1]) begin
            m_phase = 5; m_left = CLR;
         end else begin
            case (m_phase)
               5: begin m_left--; if (m_left == 0) m_phase = 0; end
               0: if (e_dly[1]) m_phase = 1;
               1: m_phase = 2;
               2: if (e_dly[1]) m_phase = 3;
               3: m_phase = 4;
               4: if (e_dly[1]) m_phase = 0;
               default: ;
            endcase
         end
         if (m_phase == 1 || m_phase == 3) m_writes++;
         e_hist = {e_hist[HW-1:0], enterBtn};
         c_hist = {c_hist[HW-1:0], clearBtn};
         nl = next_level(e_hist, e_lvl); e_dly = {e_dly[0], e_lvl & ~nl}; e_lvl = nl;
         nl = next_level(c_hist, c_lvl); c_dly = {c_dly[0], c_lvl & ~nl}; c_lvl = nl;
      end
   end

   // ---------------- drivers ----------------
   task automatic cycle(input logic e, input logic c);
      enterBtn = e; clearBtn = c;
      @(posedge clock); #1;
      if ({stage, selector, activate, memReset, sumValid} !== exp_vec(m_phase)) begin
         mism++;
         last_got = {stage, selector, activate, memReset, sumValid};
         last_exp = exp_vec(m_phase);
      end
      if (activate === 1'b0) dut_writes++;
      if (activate === 1'b0 && prev_act === 1'b0) prop_bad++;
      if (activate === 1'b0 && memReset === 1'b0) prop_bad++;
      prev_act = activate;
   endtask

   task automatic press(input logic e, input logic c, input int hold, input int gap);
      repeat (hold) cycle(e ? 1'b0 : 1'b1, c ? 1'b0 : 1'b1);
      repeat (gap) cycle(1'b1, 1'b1);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      int mr_low;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({stage, selector, activate, memReset, sumValid} !== {3'd5, 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL reset_values: got %b expected %b", {stage, selector, activate, memReset, sumValid}, {3'd5, 1'b0, 1'b1, 1'b0, 1'b0});
      else passed++;
      reset = 1'b1;
      mism = 0;
      mr_low = (memReset === 1'b0) ? 1 : 0;
      repeat (8) begin cycle(1'b1, 1'b1); if (memReset === 1'b0) mr_low++; end
      checks++;
      if (mr_low != CLR) $display("FAIL reset_clear_len: got %0d expected %0d", mr_low, CLR); else passed++;
      checks++;
      if (stage !== 3'd0) $display("FAIL reset_to_wait_a: got %0d expected 0", stage); else passed++;
      checks++;
      if (mism != 0) $display("FAIL reset_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_entry;
      int w0;
      mism = 0; w0 = dut_writes;
      press(1'b1, 1'b0, $urandom_range(8, 14), $urandom_range(10, 16));
      checks++;
      if (stage !== 3'd2 || selector !== 1'b1) $display("FAIL entry_a: got stage %0d sel %b expected stage 2 sel 1", stage, selector); else passed++;
      press(1'b1, 1'b0, $urandom_range(8, 14), $urandom_range(10, 16));
      checks++;
      if (stage !== 3'd4 || sumValid !== 1'b1) $display("FAIL entry_b: got stage %0d valid %b expected stage 4 valid 1", stage, sumValid); else passed++;
      checks++;
      if (dut_writes - w0 != 2) $display("FAIL entry_writes: got %0d expected 2", dut_writes - w0); else passed++;
      checks++;
      if (mism != 0) $display("FAIL entry_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_show_enter;
      int w0;
      mism = 0; w0 = dut_writes;
      press(1'b1, 1'b0, $urandom_range(8, 14), $urandom_range(10, 16));
      checks++;
      if ({stage, selector, sumValid} !== {3'd0, 1'b0, 1'b0}) $display("FAIL show_enter: got %b expected %b", {stage, selector, sumValid}, {3'd0, 1'b0, 1'b0}); else passed++;
      checks++;
      if (dut_writes != w0) $display("FAIL show_no_write: got %0d expected 0", dut_writes - w0); else passed++;
      checks++;
      if (mism != 0) $display("FAIL show_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_bounce;
      int w0, m0;
      mism = 0; w0 = dut_writes; m0 = m_writes;
      cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b1);
      repeat (10) cycle(1'b0, 1'b1);
      repeat (12) cycle(1'b1, 1'b1);
      checks++;
      if (dut_writes - w0 != m_writes - m0) $display("FAIL bounce_writes_model: got %0d expected %0d", dut_writes - w0, m_writes - m0); else passed++;
`ifdef DEBOUNCE_EN
      checks++;
      if (dut_writes - w0 != 1) $display("FAIL bounce_single_pulse: got %0d expected 1", dut_writes - w0); else passed++;
      checks++;
      if (stage !== 3'd2) $display("FAIL bounce_stage: got %0d expected 2", stage); else passed++;
`endif
      checks++;
      if (mism != 0) $display("FAIL bounce_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_clear_collision;
      int w0, mr_low;
      mism = 0; w0 = dut_writes; mr_low = 0;
      for (int i = 0; i < 24; i++) begin
         cycle((i < 10) ? 1'b0 : 1'b1, (i < 10) ? 1'b0 : 1'b1);
         if (memReset === 1'b0) mr_low++;
      end
      checks++;
      if (dut_writes != w0) $display("FAIL collision_no_write: got %0d expected 0", dut_writes - w0); else passed++;
      checks++;
      if (mr_low != CLR) $display("FAIL collision_clear_len: got %0d expected %0d", mr_low, CLR); else passed++;
      checks++;
      if (stage !== 3'd0) $display("FAIL collision_stage: got %0d expected 0", stage); else passed++;
      checks++;
      if (mism != 0) $display("FAIL collision_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_reset_mid_write;
      bit found;
      int mr_low;
      mism = 0; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b0, 1'b1);
         if (activate === 1'b0) found = 1;
      end
      checks++;
      if (!found) $display("FAIL midwrite_reach: got no write within 40 cycles expected one"); else passed++;
      #2 reset = 1'b0;
      enterBtn = 1'b1;
      #1;
      checks++;
      if (activate !== 1'b1 || stage !== 3'd5) $display("FAIL midwrite_async: got act %b stage %0d expected act 1 stage 5", activate, stage); else passed++;
      @(posedge clock); #1;
      reset = 1'b1;
      prev_act = activate;
      mr_low = (memReset === 1'b0) ? 1 : 0;
      repeat (10) begin cycle(1'b1, 1'b1); if (memReset === 1'b0) mr_low++; end
      checks++;
      if (mr_low != CLR || stage !== 3'd0) $display("FAIL midwrite_clear: got low %0d stage %0d expected low %0d stage 0", mr_low, stage, CLR); else passed++;
      checks++;
      if (mism != 0) $display("FAIL midwrite_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   task automatic test_random;
      int w0, m0, nb;
      logic c;
      mism = 0; prop_bad = 0; w0 = dut_writes; m0 = m_writes;
      repeat (40) begin
         c = ($urandom_range(0, 4) == 0);
         nb = $urandom_range(0, 3);
         for (int i = 0; i < nb; i++) cycle(c | i[0], !c | i[0]);
         repeat ($urandom_range(6, 12)) cycle(c, !c);
         for (int i = 0; i < nb; i++) cycle(!i[0] | c, !i[0] | !c);
         repeat ($urandom_range(6, 12)) cycle(1'b1, 1'b1);
      end
      checks++;
      if (dut_writes - w0 != m_writes - m0) $display("FAIL random_writes: got %0d expected %0d", dut_writes - w0, m_writes - m0); else passed++;
      checks++;
      if (prop_bad != 0) $display("FAIL random_activate_rules: got %0d violations expected 0", prop_bad); else passed++;
      checks++;
      if (mism != 0) $display("FAIL random_model: %0d bad cycles, got %b expected %b", mism, last_got, last_exp); else passed++;
   endtask

   initial begin
      test_reset();
      test_entry();
      test_show_enter();
      test_bounce();
      test_clear_collision();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
